// File: rtl/mux_out_filter_if.sv
// Handshake-free signal bundle between the mux output filter and its environment.
// master drives en/clr/y_in and observes the filtered outputs; slave is the filter.
interface mux_out_filter_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             clr;
  logic             y_in;
  logic             y_filt;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] rise_cnt;

  modport master (
    output en, clr, y_in,
    input  y_filt, rise_pulse, fall_pulse, rise_cnt
  );

  modport slave (
    input  en, clr, y_in,
    output y_filt, rise_pulse, fall_pulse, rise_cnt
  );
endinterface

// File: rtl/mux_out_filter.sv
// Synchronises and deglitches the mux output y, emits edge pulses and counts accepted rises.
// Optional macro MUX_FILT_SAT_EN: rise_cnt saturates at all ones instead of wrapping.
module mux_out_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8   // must match the CNT_W of the connected interface
) (
  input  logic               clk,
  input  logic               reset_n,
  mux_out_filter_if.slave    bus
);

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [STAB_W-1:0]      stab_q, stab_d;
  logic                   filt_q, filt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // A mismatching level is accepted on its STABLE_CYCLES-th consecutive mismatching
  // enabled cycle; any return to the filtered level restarts the count.
  always_comb begin
    stab_d = stab_q;
    filt_d = filt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    cnt_d  = cnt_q;
    if (bus.en) begin
      if (s == filt_q) begin
        stab_d = '0;
      end else if (stab_q == STAB_LAST) begin
        filt_d = s;
        stab_d = '0;
        rise_d = s;
        fall_d = ~s;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end
    if (bus.clr) begin
      cnt_d = '0;
    end else if (rise_d) begin
`ifdef MUX_FILT_SAT_EN
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`else
      cnt_d = cnt_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      stab_q <= '0;
      filt_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.y_in};
      stab_q <= stab_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.y_filt     = filt_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.rise_cnt   = cnt_q;

endmodule

// File: tb/tb_mux_out_filter.sv
// Bench for mux_out_filter: per-cycle stimulus/expectation records plus hand sequences
// for counter wrap/saturation and reset in the middle of a stability count.
module tb_mux_out_filter;

  localparam int CNT_W = 4;
  localparam int EXP_W = 3 + CNT_W;
`ifdef MUX_FILT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  int   cyc;

  logic [EXP_W-1:0] exp_q[$];

  mux_out_filter_if #(.CNT_W(CNT_W)) bus ();

  mux_out_filter #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .CNT_W        (CNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string            name;
    int               rep;
    logic             rst_n;
    logic             y;
    logic             en;
    logic             clr;
    logic             e_filt;
    logic             e_rise;
    logic             e_fall;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  // driver + scoreboard: inputs change on the falling edge, the expectation is queued,
  // and outputs are compared 1ns after the following rising edge.
  task automatic run(input string name, input int rep, input logic rst_n, input logic y,
                     input logic en, input logic clr, input logic e_filt, input logic e_rise,
                     input logic e_fall, input logic [CNT_W-1:0] e_cnt);
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] exp;
    for (int i = 0; i < rep; i++) begin
      @(negedge clk);
      reset_n  = rst_n;
      bus.y_in = y;
      bus.en   = en;
      bus.clr  = clr;
      exp_q.push_back({e_filt, e_rise, e_fall, e_cnt});
      @(posedge clk);
      #1;
      cyc++;
      got = {bus.y_filt, bus.rise_pulse, bus.fall_pulse, bus.rise_cnt};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got filt=%b rise=%b fall=%b cnt=%0d, expected filt=%b rise=%b fall=%b cnt=%0d",
                 name, cyc, got[EXP_W-1], got[EXP_W-2], got[EXP_W-3], got[CNT_W-1:0],
                 exp[EXP_W-1], exp[EXP_W-2], exp[EXP_W-3], exp[CNT_W-1:0]);
      end
    end
  endtask

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c);
    if (SAT && c == '1) return c;
    return c + 1'b1;
  endfunction

  // One clean rise then fall; the new level is sampled on the first edge of each run
  // and y_filt flips on the sixth edge counted from that sampling edge.
  task automatic rise_fall(input string name, input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] n;
    n = next_cnt(c);
    run(name, 5, 1, 1, 1, 0, 0, 0, 0, c);
    run(name, 1, 1, 1, 1, 0, 1, 1, 0, n);
    run(name, 5, 1, 0, 1, 0, 1, 0, 0, n);
    run(name, 1, 1, 0, 1, 0, 0, 0, 1, n);
  endtask

  initial begin
    logic [CNT_W-1:0] c;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    reset_n = 1'b0;
    bus.y_in = 1'b0;
    bus.en   = 1'b0;
    bus.clr  = 1'b0;

    //               name         rep rst y  en clr filt rise fall cnt
    tbl.push_back('{"reset",       2, 0, 1, 1, 1,   0,   0,   0, 4'd0});
    tbl.push_back('{"idle",        4, 1, 0, 1, 0,   0,   0,   0, 4'd0});
    tbl.push_back('{"glitch_hi",   3, 1, 1, 1, 0,   0,   0,   0, 4'd0});
    tbl.push_back('{"glitch_lo",   8, 1, 0, 1, 0,   0,   0,   0, 4'd0});
    tbl.push_back('{"rise_wait",   5, 1, 1, 1, 0,   0,   0,   0, 4'd0});
    tbl.push_back('{"rise_acc",    1, 1, 1, 1, 0,   1,   1,   0, 4'd1});
    tbl.push_back('{"rise_hold",   3, 1, 1, 1, 0,   1,   0,   0, 4'd1});
    tbl.push_back('{"fall_wait",   5, 1, 0, 1, 0,   1,   0,   0, 4'd1});
    tbl.push_back('{"fall_acc",    1, 1, 0, 1, 0,   0,   0,   1, 4'd1});
    tbl.push_back('{"fall_hold",   2, 1, 0, 1, 0,   0,   0,   0, 4'd1});
    tbl.push_back('{"en0_step",   10, 1, 1, 0, 0,   0,   0,   0, 4'd1});
    tbl.push_back('{"en1_count",   3, 1, 1, 1, 0,   0,   0,   0, 4'd1});
    tbl.push_back('{"en1_acc",     1, 1, 1, 1, 0,   1,   1,   0, 4'd2});
    tbl.push_back('{"en1_hold",    2, 1, 1, 1, 0,   1,   0,   0, 4'd2});
    tbl.push_back('{"part_cnt",    4, 1, 0, 1, 0,   1,   0,   0, 4'd2});
    tbl.push_back('{"part_en0",    5, 1, 0, 0, 0,   1,   0,   0, 4'd2});
    tbl.push_back('{"part_resume", 1, 1, 0, 1, 0,   1,   0,   0, 4'd2});
    tbl.push_back('{"part_acc",    1, 1, 0, 1, 0,   0,   0,   1, 4'd2});
    tbl.push_back('{"part_hold",   2, 1, 0, 1, 0,   0,   0,   0, 4'd2});
    tbl.push_back('{"clr_wait",    5, 1, 1, 1, 0,   0,   0,   0, 4'd2});
    tbl.push_back('{"clr_on_acc",  1, 1, 1, 1, 1,   1,   1,   0, 4'd0});
    tbl.push_back('{"clr_after",   2, 1, 1, 1, 0,   1,   0,   0, 4'd0});
    tbl.push_back('{"clr_fall_w",  5, 1, 0, 1, 0,   1,   0,   0, 4'd0});
    tbl.push_back('{"clr_fall",    1, 1, 0, 1, 0,   0,   0,   1, 4'd0});
    tbl.push_back('{"clr_idle",    2, 1, 0, 1, 0,   0,   0,   0, 4'd0});

    foreach (tbl[k]) begin
      run(tbl[k].name, tbl[k].rep, tbl[k].rst_n, tbl[k].y, tbl[k].en, tbl[k].clr,
          tbl[k].e_filt, tbl[k].e_rise, tbl[k].e_fall, tbl[k].e_cnt);
    end

    // 16 clean rising edges on a 4-bit counter: wraps to 0, or sticks at 15 when saturating
    c = '0;
    for (int i = 0; i < 16; i++) begin
      rise_fall("wrap", c);
      c = next_cnt(c);
    end
    run("wrap_final", 1, 1, 0, 1, 0, 0, 0, 0, SAT ? 4'd15 : 4'd0);
    run("wrap_clr",   1, 1, 0, 1, 1, 0, 0, 0, 4'd0);
    run("clr_lvl",    1, 1, 0, 1, 0, 0, 0, 0, 4'd0);

    // build one accepted rise so reset has a non-zero count to clear
    rise_fall("pre_rst", 4'd0);
    // y_in=1 held until stab_cnt reaches 2, then reset for two edges
    run("mid_cnt",    4, 1, 1, 1, 0, 0, 0, 0, 4'd1);
    run("mid_rst",    2, 0, 1, 1, 0, 0, 0, 0, 4'd0);
    run("post_wait",  5, 1, 1, 1, 0, 0, 0, 0, 4'd0);
    run("post_acc",   1, 1, 1, 1, 0, 1, 1, 0, 4'd1);
    run("post_hold",  2, 1, 1, 1, 0, 1, 0, 0, 4'd1);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
